// File: rtl/wb_unit_if.sv
// Writeback bundle: ALU result channel, load response channel, register-file write port
// and the pending-write mask.
interface wb_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned XLEN   = 32
);
    logic                   alu_valid;
    logic [REG_AW-1:0]      alu_rd;
    logic [XLEN-1:0]        alu_data;
    logic                   alu_ready;

    logic                   ld_valid;
    logic [REG_AW-1:0]      ld_rd;
    logic [2:0]             ld_funct3;
    logic [1:0]             ld_addr_lo;
    logic [XLEN-1:0]        ld_rdata;
    logic                   ld_ready;

    logic                   w_enable;
    logic [REG_AW-1:0]      w_addr;
    logic [XLEN-1:0]        w_data;
    logic [(1<<REG_AW)-1:0] pend_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
        input  alu_ready, ld_ready,
        input  w_enable, w_addr, w_data, pend_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
        output alu_ready, ld_ready,
        output w_enable, w_addr, w_data, pend_mask
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: merges ALU results and extended load responses (via a small FIFO)
// into one registered register-file write port, exporting a pending-write mask.
module wb_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned XLEN       = 32
) (
    input  logic       clk,
    input  logic       rst,
    wb_unit_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned NREG  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    wb_entry_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_w_enable;
    logic [REG_AW-1:0] r_w_addr;
    logic [XLEN-1:0]   r_w_data;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_alu_win;
    logic [XLEN-1:0]   w_ld_ext;
    wb_entry_t         w_head;
    logic [NREG-1:0]   w_pend;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] raw
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return raw;
        endcase
    endfunction

    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign bus.ld_ready  = rst && !w_full;
    assign bus.alu_ready = rst && !w_full;
    assign w_push        = bus.ld_valid && bus.ld_ready;
    assign w_alu_win     = bus.alu_valid && bus.alu_ready;
    // A full FIFO outranks the ALU; otherwise the head only goes when the ALU is idle.
    assign w_pop         = w_full || (!bus.alu_valid && !w_empty);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_ld_ext      = load_extend(bus.ld_funct3, bus.ld_addr_lo, bus.ld_rdata);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.ld_rd, w_ld_ext};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_w_enable <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            if (w_pop) begin
                r_w_enable <= (w_head.rd != '0);
                r_w_addr   <= w_head.rd;
                r_w_data   <= w_head.data;
            end else if (w_alu_win) begin
                r_w_enable <= (bus.alu_rd != '0);
                r_w_addr   <= bus.alu_rd;
                r_w_data   <= bus.alu_data;
            end else begin
                r_w_enable <= 1'b0;
            end
        end
    end

    // Walk the live FIFO entries from the head; x0 is never a hazard.
    always_comb begin
        w_pend = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < r_count) begin
                w_pend[r_mem[PTR_W'(r_rd_ptr + PTR_W'(i))].rd] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    assign bus.w_enable  = r_w_enable;
    assign bus.w_addr    = r_w_addr;
    assign bus.w_data    = r_w_data;
    assign bus.pend_mask = w_pend;
endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback stage that produces the register-file write port (w_enable, w_addr, w_data).
- Merges two result sources:
  - single-cycle ALU results from the EX/MEM pipeline;
  - variable-latency load responses from the data-memory interface.
- Load data is sign- or zero-extended and held in a 2-entry FIFO; a fixed-priority arbiter drains one result per cycle into a registered write port.
- Exports a pending-write mask so decode can block hazards on queued loads.

Parameters:
- FIFO_DEPTH, 2, load-result FIFO entries (power of two, minimum 2).
- REG_AW, 5, register address width.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising edge).
- alu_valid  in  1  ALU result presented.
- alu_rd  in  REG_AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result consumed this cycle when alu_valid&&alu_ready; combinational.
- ld_valid  in  1  load response presented.
- ld_rd  in  REG_AW  load destination register.
- ld_funct3  in  3  load type (RV32I funct3).
- ld_addr_lo  in  2  byte offset of the load address.
- ld_rdata  in  XLEN  raw aligned memory word.
- ld_ready  out  1  FIFO accepts the response when ld_valid&&ld_ready.
- w_enable  out  1  register-file write enable; registered.
- w_addr  out  REG_AW  register-file write address; registered.
- w_data  out  XLEN  register-file write data; registered.
- pend_mask  out  2**REG_AW  bit r set while a FIFO entry targets register r; combinational from FIFO state.

Behaviour:
- Reset (rst==0 at a clock edge):
  - FIFO count, read pointer and write pointer are set to 0.
  - w_enable=0, w_addr=0, w_data=0.
  - While rst==0: alu_ready=0 and ld_ready=0; pend_mask reads 0 once the reset edge has occurred.
  - Reset mid-operation discards all queued entries and any in-flight output; nothing is written afterwards.
- Extension at enqueue (FIFO stores the final value):
  - funct3 000 LB: byte selected by addr_lo, sign-extended.
  - 001 LH: half selected by addr_lo[1], sign-extended; addr_lo[0] ignored.
  - 010 LW: word unchanged.
  - 100 LBU / 101 LHU: as LB / LH but zero-extended.
  - Any other funct3: treated as LW.
- ld_ready = (count < FIFO_DEPTH), from registered count.
  - A full FIFO never accepts, even when popping in the same cycle.
  - A push into a non-full FIFO concurrent with a pop is legal.
- Arbitration, one winner per cycle:
  1. If FIFO is full, the FIFO head wins and alu_ready=0.
  2. Else if alu_valid, the ALU wins, alu_ready=1, and the FIFO head (if any) waits.
  3. Else if FIFO is non-empty, the FIFO head wins.
  4. When the FIFO is not full, alu_ready=1 regardless of alu_valid.
- Output register, next edge after a win:
  - w_enable = (winner rd != 0); w_addr = rd; w_data = value.
  - rd==0 results are consumed but never written.
  - With no winner, w_enable=0 and w_addr/w_data hold their previous values.
- Latency:
  - ALU result: w_enable asserted 1 cycle after acceptance.
  - Load: at least 2 cycles (enqueue edge, then head selected, then output edge).
  - FIFO order is strictly preserved.
- pend_mask is the OR of one-hot(rd) over valid FIFO entries, with bit 0 forced to 0. Entries already in the output register are not pending; the register file forwards the write data.
- Ordering: the issuing pipeline uses pend_mask to guarantee no ALU result targets a register pending in the FIFO. wb_unit does not reorder or merge entries.
- Throughput: at most one register-file write per cycle.
  - Sustained ALU traffic starves loads until the FIFO fills.
  - Once full, the FIFO drains one entry, alu_ready returns high the following cycle, and priority returns to the ALU.

Test Plan:
- Reset: hold rst=0 for 3 cycles with alu_valid=1 -> w_enable=0, w_addr=0, w_data=0, alu_ready=0, ld_ready=0, pend_mask=0; first write appears only after rst=1.
- ALU path: alu_valid=1, rd=5, data=0x1234 -> next cycle w_enable=1, w_addr=5, w_data=0x1234. Then rd=0, data=0xFFFF -> w_enable=0.
- Load extension, each enqueued alone with rd=7 and raw word 0x80F0_7F81 -> exactly 2 cycles later:
  - LB off=0 -> 0xFFFF_FF81
  - LBU off=1 -> 0x0000_007F
  - LH off=2 -> 0xFFFF_80F0
  - LHU off=3 -> 0x0000_80F0
  - LW -> 0x80F0_7F81
  - funct3=011 -> 0x80F0_7F81
- Priority: enqueue a load to rd=3 while alu_valid stays high with rd=4,6 -> ALU writes 4 then 6 first. pend_mask[3]=1 until the load is dequeued, then x3 is written when alu_valid drops.
- Full FIFO: enqueue 2 loads (rd=8, rd=9) under continuous alu_valid -> ld_ready=0 and alu_ready=0 in the following cycle. x8 is written, then alu_ready returns to 1 and ld_ready returns to 1; a third load offered while full is not accepted until ld_ready=1.
- Mid-operation reset: 2 queued loads plus a pending output, assert rst=0 for 1 cycle -> no further w_enable, pend_mask=0, count=0.
